// File: rtl/inst_fetcher.sv
// Instruction fetch front end: issues in-order reads on the memory request port, buffers
// returned words tagged with their PC, and hands them to decode; flush redirects and squashes.
module inst_fetcher #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_valid,
    input  logic [31:0]           flush_pc,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [31:0]           o_pc,
    output logic [31:0]           o_inst,
    input  logic                  membus_ready,
    output logic                  membus_valid,
    output logic                  membus_wen,
    output logic [ADDR_WIDTH-1:0] membus_addr,
    output logic [31:0]           membus_wdata,
    output logic [3:0]            membus_wmask,
    input  logic                  membus_rvalid,
    input  logic [31:0]           membus_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_inst [FIFO_DEPTH];

    logic          w_issue;
    logic          w_accept;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occupancy;
    logic [31:0]   w_flush_pc;

    // Buffered plus outstanding entries; keeping this below depth makes overflow impossible.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue     = !rst && !flush_valid && membus_ready
                         && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign w_accept    = w_issue && membus_ready;
    // A response with nothing outstanding is a leftover from before reset and is ignored.
    assign w_rsp       = membus_rvalid && (r_inflight != '0);
    assign w_push      = w_rsp && (r_discard == '0) && !flush_valid;
    assign w_pop       = o_valid && o_ready && !flush_valid;
    assign w_flush_pc  = flush_pc & 32'hFFFF_FFFC;

    assign membus_valid = w_issue;
    assign membus_wen   = 1'b0;
    assign membus_wdata = 32'h0;
    assign membus_wmask = 4'h0;
    assign membus_addr  = r_fetch_pc[ADDR_WIDTH+1:2];

    assign o_valid = !rst && (r_count != '0);
    assign o_pc    = r_fifo_pc[r_head];
    assign o_inst  = r_fifo_inst[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_rsp);
            if (flush_valid) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                r_fetch_pc <= w_flush_pc;
                r_resp_pc  <= w_flush_pc;
                r_discard  <= r_inflight - CW'(w_rsp);
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_tail    <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage carries no reset; contents are only observed while o_valid is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_tail]   <= r_resp_pc;
            r_fifo_inst[r_tail] <= membus_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a latency-configurable memory model answers requests,
// and each scenario task checks fetch order, timing, flush and reset behaviour.
module tb_inst_fetcher;
    logic        clk;
    logic        rst;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        membus_ready;
    logic        membus_valid;
    logic        membus_wen;
    logic [15:0] membus_addr;
    logic [31:0] membus_wdata;
    logic [3:0]  membus_wmask;
    logic        membus_rvalid;
    logic [31:0] membus_rdata;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int lat        = 1;
    logic stray_rv = 1'b0;

    logic [15:0] req_log  [$];
    int          pend_due [$];
    logic [15:0] pend_addr[$];
    logic [31:0] pop_pc   [$];
    logic [31:0] pop_inst [$];

    inst_fetcher #(
        .ADDR_WIDTH(16),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_valid  (flush_valid),
        .flush_pc     (flush_pc),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_pc         (o_pc),
        .o_inst       (o_inst),
        .membus_ready (membus_ready),
        .membus_valid (membus_valid),
        .membus_wen   (membus_wen),
        .membus_addr  (membus_addr),
        .membus_wdata (membus_wdata),
        .membus_wmask (membus_wmask),
        .membus_rvalid(membus_rvalid),
        .membus_rdata (membus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0040) return 32'h0000_0013;
        return {a, ~a};
    endfunction

    // Samples the current cycle, advances one clock, then drives the memory response.
    task automatic tick();
        logic        acc;
        logic [15:0] a;
        #1;
        acc = membus_valid && membus_ready;
        a   = membus_addr;
        if (acc) begin
            req_log.push_back(a);
            pend_due.push_back(cyc + lat);
            pend_addr.push_back(a);
        end
        if (o_valid && o_ready && !flush_valid) begin
            pop_pc.push_back(o_pc);
            pop_inst.push_back(o_inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        membus_rvalid = 1'b0;
        membus_rdata  = 32'hDEAD_BEEF;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            membus_rvalid = 1'b1;
            membus_rdata  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else if (stray_rv) begin
            membus_rvalid = 1'b1;
            membus_rdata  = 32'hBAD0_BAD0;
        end
        stray_rv = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
        cyc = 0;
    endtask

    task automatic do_reset(input logic rdy);
        rst          = 1'b1;
        flush_valid  = 1'b0;
        flush_pc     = 32'h0;
        membus_ready = 1'b1;
        o_ready      = rdy;
        repeat (2) tick();
        pend_due.delete();
        pend_addr.delete();
        rst = 1'b0;
        clear_logs();
    endtask

    // Occupancy invariant observed every cycle outside reset.
    always @(negedge clk) begin
        if (!rst && (int'(dut.r_count) + int'(dut.r_inflight) > 4)) begin
            miscompares++;
            $display("FAIL occupancy: got %0d, limit 4", int'(dut.r_count) + int'(dut.r_inflight));
        end
    end

    task automatic test_reset();
        repeat (2) tick();
        #1;
        vectors++; if (membus_valid !== 1'b0) begin miscompares++; $display("FAIL rst_membus_valid: got %b expected 0", membus_valid); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_o_valid: got %b expected 0", o_valid); end
        vectors++; if (membus_wen !== 1'b0 || membus_wmask !== 4'h0 || membus_wdata !== 32'h0) begin miscompares++; $display("FAIL write_consts: got %b %h %h expected 0 0 0", membus_wen, membus_wmask, membus_wdata); end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0; o_ready = 1'b1; lat = 1;
        pend_due.delete(); pend_addr.delete();
        clear_logs();
        #1;
        vectors++; if (membus_valid !== 1'b1 || membus_addr !== 16'h0040) begin miscompares++; $display("FAIL first_req: got %b/%h expected 1/0040", membus_valid, membus_addr); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL first_c1_valid: got %b expected 0", o_valid); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== 32'h13) begin miscompares++; $display("FAIL first_c2: got %b %h %h expected 1 00000100 00000013", o_valid, o_pc, o_inst); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h104 || o_inst !== 32'h0041FFBE) begin miscompares++; $display("FAIL first_c3: got %b %h %h expected 1 00000104 0041ffbe", o_valid, o_pc, o_inst); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h108 || o_inst !== 32'h0042FFBD) begin miscompares++; $display("FAIL first_c4: got %b %h %h expected 1 00000108 0042ffbd", o_valid, o_pc, o_inst); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0); lat = 1;
        repeat (10) tick();
        vectors++; if (req_log.size() != 4) begin miscompares++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h100) begin miscompares++; $display("FAIL bp_head: got %b %h expected 1 00000100", o_valid, o_pc); end
        #1;
        vectors++; if (membus_valid !== 1'b0) begin miscompares++; $display("FAIL bp_stalled: got %b expected 0", membus_valid); end
        o_ready = 1'b1;
        repeat (8) tick();
        vectors++; if (req_log.size() != 11) begin miscompares++; $display("FAIL bp_req_total: got %0d expected 11", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            vectors++; if (req_log[i] !== 16'(16'h40 + i)) begin miscompares++; $display("FAIL bp_req_addr[%0d]: got %h expected %h", i, req_log[i], 16'(16'h40 + i)); end
        end
        vectors++; if (pop_pc.size() != 8) begin miscompares++; $display("FAIL bp_pop_count: got %0d expected 8", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            vectors++; if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_inst[i] !== mem_word(16'(16'h40 + i))) begin miscompares++; $display("FAIL bp_pop[%0d]: got %h/%h expected %h/%h", i, pop_pc[i], pop_inst[i], 32'h100 + 32'(4 * i), mem_word(16'(16'h40 + i))); end
        end
    endtask

    task automatic test_flush();
        do_reset(1'b1); lat = 2;
        repeat (2) tick();
        flush_valid = 1'b1; flush_pc = 32'h0000_2000;
        #1;
        vectors++; if (membus_valid !== 1'b0) begin miscompares++; $display("FAIL fl_no_issue: got %b expected 0", membus_valid); end
        tick();
        flush_valid = 1'b0;
        #1;
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL fl_empty: got %b expected 0", o_valid); end
        vectors++; if (membus_valid !== 1'b1 || membus_addr !== 16'h0800) begin miscompares++; $display("FAIL fl_req: got %b/%h expected 1/0800", membus_valid, membus_addr); end
        repeat (6) tick();
        vectors++; if (pop_pc.size() != 3) begin miscompares++; $display("FAIL fl_pop_count: got %0d expected 3", pop_pc.size()); end
        else begin
            vectors++; if (pop_pc[0] !== 32'h2000 || pop_inst[0] !== 32'h0800F7FF) begin miscompares++; $display("FAIL fl_pop0: got %h/%h expected 00002000/0800f7ff", pop_pc[0], pop_inst[0]); end
            vectors++; if (pop_pc[1] !== 32'h2004 || pop_inst[1] !== 32'h0801F7FE) begin miscompares++; $display("FAIL fl_pop1: got %h/%h expected 00002004/0801f7fe", pop_pc[1], pop_inst[1]); end
        end
        // Single-cycle memory: redirect while a response is arriving, first word at T+3.
        do_reset(1'b1); lat = 1;
        repeat (3) tick();
        flush_valid = 1'b1; flush_pc = 32'h0000_3002;
        tick();
        flush_valid = 1'b0;
        #1;
        vectors++; if (o_valid !== 1'b0 || membus_valid !== 1'b1 || membus_addr !== 16'h0C00) begin miscompares++; $display("FAIL fl1_t1: got %b %b %h expected 0 1 0c00", o_valid, membus_valid, membus_addr); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL fl1_t2: got %b expected 0", o_valid); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h3000 || o_inst !== 32'h0C00F3FF) begin miscompares++; $display("FAIL fl1_t3: got %b %h %h expected 1 00003000 0c00f3ff", o_valid, o_pc, o_inst); end
    endtask

    task automatic test_ready_toggle();
        do_reset(1'b1); lat = 1;
        for (int i = 0; i < 8; i++) begin
            membus_ready = ((i % 2) == 0);
            #1;
            vectors++; if (membus_valid !== ((i % 2) == 0)) begin miscompares++; $display("FAIL tg_valid[%0d]: got %b expected %b", i, membus_valid, (i % 2) == 0); end
            tick();
        end
        membus_ready = 1'b1;
        repeat (6) tick();
        vectors++; if (req_log.size() != 10) begin miscompares++; $display("FAIL tg_req_count: got %0d expected 10", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            vectors++; if (req_log[i] !== 16'(16'h40 + i)) begin miscompares++; $display("FAIL tg_req_addr[%0d]: got %h expected %h", i, req_log[i], 16'(16'h40 + i)); end
        end
        vectors++; if (pop_pc.size() != 8) begin miscompares++; $display("FAIL tg_pop_count: got %0d expected 8", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            vectors++; if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_inst[i] !== mem_word(16'(16'h40 + i))) begin miscompares++; $display("FAIL tg_pop[%0d]: got %h/%h expected %h/%h", i, pop_pc[i], pop_inst[i], 32'h100 + 32'(4 * i), mem_word(16'(16'h40 + i))); end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(1'b0); lat = 1;
        repeat (3) tick();
        rst = 1'b1; stray_rv = 1'b1;
        #1;
        vectors++; if (o_valid !== 1'b0 || membus_valid !== 1'b0) begin miscompares++; $display("FAIL mr_in_rst: got %b %b expected 0 0", o_valid, membus_valid); end
        tick();
        rst = 1'b0; o_ready = 1'b1;
        #1;
        vectors++; if (o_valid !== 1'b0 || membus_valid !== 1'b1 || membus_addr !== 16'h0040) begin miscompares++; $display("FAIL mr_release: got %b %b %h expected 0 1 0040", o_valid, membus_valid, membus_addr); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mr_stray_ignored: got %b expected 0", o_valid); end
        tick();
        vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_inst !== 32'h13) begin miscompares++; $display("FAIL mr_first: got %b %h %h expected 1 00000100 00000013", o_valid, o_pc, o_inst); end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1); lat = 1;
        flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC;
        tick();
        flush_valid = 1'b0;
        #1;
        vectors++; if (membus_valid !== 1'b1 || membus_addr !== 16'hFFFF) begin miscompares++; $display("FAIL wr_req0: got %b/%h expected 1/ffff", membus_valid, membus_addr); end
        tick();
        vectors++; if (membus_valid !== 1'b1 || membus_addr !== 16'h0000) begin miscompares++; $display("FAIL wr_req1: got %b/%h expected 1/0000", membus_valid, membus_addr); end
        repeat (4) tick();
        vectors++; if (pop_pc.size() < 2) begin miscompares++; $display("FAIL wr_pop_count: got %0d expected >=2", pop_pc.size()); end
        else begin
            vectors++; if (pop_pc[0] !== 32'hFFFF_FFFC || pop_inst[0] !== 32'hFFFF_0000) begin miscompares++; $display("FAIL wr_pop0: got %h/%h expected fffffffc/ffff0000", pop_pc[0], pop_inst[0]); end
            vectors++; if (pop_pc[1] !== 32'h0 || pop_inst[1] !== 32'h0000_FFFF) begin miscompares++; $display("FAIL wr_pop1: got %h/%h expected 00000000/0000ffff", pop_pc[1], pop_inst[1]); end
        end
    endtask

    initial begin
        rst = 1'b1; flush_valid = 1'b0; flush_pc = 32'h0;
        o_ready = 1'b0; membus_ready = 1'b1;
        membus_rvalid = 1'b0; membus_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_flush();
        test_ready_toggle();
        test_reset_midflight();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
